// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the hard-wired zero register and the default counter width.
package hazard_control_unit_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } hcu_state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         CNT_W_DEF = 32;

  // A source register matches a destination only when it is actually read
  // and is not x0 (x0 writes are discarded, so never a real dependency).
  function automatic logic reg_match(input logic [4:0] rs,
                                     input logic       use_rs,
                                     input logic [4:0] rd);
    return use_rs && (rs != REG_ZERO) && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module hz_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count qualifying cycles; stop at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipe. Inserts bubbles for hazards
// forwarding cannot resolve, freezes the pipe on cache misses, defers a
// taken-branch flush seen during a freeze, and counts stall/bubble cycles.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | pipe flowing; hazards produce bubbles, taken branches flush
//   ST_FREEZE | a cache miss was seen last cycle; exits on first clear cycle
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFID_RS1,
  input  logic [4:0]       IFID_RS2,
  input  logic             IFID_USE_RS1,
  input  logic             IFID_USE_RS2,
  input  logic             IFID_BRANCH,
  input  logic             BRANCH_TAKEN,
  input  logic [4:0]       IDEX_RD,
  input  logic             IDEX_RegWrite,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       EXMEM_RD,
  input  logic             EXMEM_MemRead,
  input  logic             ICACHE_STALL,
  input  logic             DCACHE_STALL,
  output logic             PC_WRITE,
  output logic             IFID_WRITE,
  output logic             IFID_FLUSH,
  output logic             IDEX_BUBBLE,
  output logic             PIPE_FREEZE,
  output logic [CNT_W-1:0] STALL_CYCLES,
  output logic [CNT_W-1:0] BUBBLE_CYCLES
);

  hcu_state_e state, state_next;
  logic       flush_pend;
  logic       stall_any;
  logic       match_ex, match_mem;
  logic       hz_lu, hz_ba, hz_bl, hz;

  assign stall_any = ICACHE_STALL | DCACHE_STALL;

  assign match_ex  = reg_match(IFID_RS1, IFID_USE_RS1, IDEX_RD) |
                     reg_match(IFID_RS2, IFID_USE_RS2, IDEX_RD);
  assign match_mem = reg_match(IFID_RS1, IFID_USE_RS1, EXMEM_RD) |
                     reg_match(IFID_RS2, IFID_USE_RS2, EXMEM_RD);

  // Load in EX always stalls; a branch in ID also waits on an ALU result in
  // EX or a load still in MEM, since its operands are compared in ID.
  assign hz_lu = IDEX_MemRead & match_ex;
  assign hz_ba = IFID_BRANCH & IDEX_RegWrite & ~IDEX_MemRead & match_ex;
  assign hz_bl = IFID_BRANCH & EXMEM_MemRead & match_mem;
  assign hz    = hz_lu | hz_ba | hz_bl;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // Next state and pipe controls; freeze beats hazard beats flush. The stall
  // inputs act combinationally, so the freeze exit cycle already flows.
  always_comb begin
    state_next  = state;
    PC_WRITE    = 1'b1;
    IFID_WRITE  = 1'b1;
    IFID_FLUSH  = 1'b0;
    IDEX_BUBBLE = 1'b0;
    PIPE_FREEZE = 1'b0;
    case (state)
      ST_RUN:    if (stall_any)  state_next = ST_FREEZE;
      ST_FREEZE: if (!stall_any) state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
    if (rst) begin
      state_next = ST_RUN;
    end else if (stall_any) begin
      PIPE_FREEZE = 1'b1;
      PC_WRITE    = 1'b0;
      IFID_WRITE  = 1'b0;
    end else if (hz) begin
      PC_WRITE    = 1'b0;
      IFID_WRITE  = 1'b0;
      IDEX_BUBBLE = 1'b1;
    end else begin
      IFID_FLUSH  = BRANCH_TAKEN | flush_pend;
    end
  end

  // Remember a redirect resolved while frozen so exactly one flush follows.
  always_ff @(posedge clk) begin
    if (rst)                                   flush_pend <= 1'b0;
    else if (stall_any && BRANCH_TAKEN && !hz) flush_pend <= 1'b1;
    else if (IFID_FLUSH)                       flush_pend <= 1'b0;
  end

  hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (PIPE_FREEZE),
    .count (STALL_CYCLES)
  );

  hz_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (IDEX_BUBBLE),
    .count (BUBBLE_CYCLES)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with 4-bit counters.
module tb_hazard_control_unit;

  localparam int W = 4;
  // Control vector order: {PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_BUBBLE, PIPE_FREEZE}
  localparam logic [4:0] C_RUN    = 5'b11000;
  localparam logic [4:0] C_FLUSH  = 5'b11100;
  localparam logic [4:0] C_BUBBLE = 5'b00010;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] IFID_RS1, IFID_RS2, IDEX_RD, EXMEM_RD;
  logic IFID_USE_RS1, IFID_USE_RS2, IFID_BRANCH, BRANCH_TAKEN;
  logic IDEX_RegWrite, IDEX_MemRead, EXMEM_MemRead, ICACHE_STALL, DCACHE_STALL;
  logic PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_BUBBLE, PIPE_FREEZE;
  logic [W-1:0] STALL_CYCLES, BUBBLE_CYCLES;
  logic [4:0] ctl;

  int n_cmp = 0;
  int n_fail = 0;

  assign ctl = {PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_BUBBLE, PIPE_FREEZE};

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .IFID_RS1      (IFID_RS1),
    .IFID_RS2      (IFID_RS2),
    .IFID_USE_RS1  (IFID_USE_RS1),
    .IFID_USE_RS2  (IFID_USE_RS2),
    .IFID_BRANCH   (IFID_BRANCH),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .IDEX_RD       (IDEX_RD),
    .IDEX_RegWrite (IDEX_RegWrite),
    .IDEX_MemRead  (IDEX_MemRead),
    .EXMEM_RD      (EXMEM_RD),
    .EXMEM_MemRead (EXMEM_MemRead),
    .ICACHE_STALL  (ICACHE_STALL),
    .DCACHE_STALL  (DCACHE_STALL),
    .PC_WRITE      (PC_WRITE),
    .IFID_WRITE    (IFID_WRITE),
    .IFID_FLUSH    (IFID_FLUSH),
    .IDEX_BUBBLE   (IDEX_BUBBLE),
    .PIPE_FREEZE   (PIPE_FREEZE),
    .STALL_CYCLES  (STALL_CYCLES),
    .BUBBLE_CYCLES (BUBBLE_CYCLES)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IFID_RS1 = 5'd0; IFID_RS2 = 5'd0; IFID_USE_RS1 = 1'b0; IFID_USE_RS2 = 1'b0;
    IFID_BRANCH = 1'b0; BRANCH_TAKEN = 1'b0;
    IDEX_RD = 5'd0; IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0;
    EXMEM_RD = 5'd0; EXMEM_MemRead = 1'b0;
    ICACHE_STALL = 1'b0; DCACHE_STALL = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // EX: lw x5 ; ID: add x6,x5,x1
  task automatic set_load_use();
    IDEX_RD = 5'd5; IDEX_RegWrite = 1'b1; IDEX_MemRead = 1'b1;
    IFID_RS1 = 5'd5; IFID_USE_RS1 = 1'b1; IFID_RS2 = 5'd1; IFID_USE_RS2 = 1'b1;
  endtask

  task automatic test_reset();
    set_load_use();
    IFID_BRANCH = 1'b1; BRANCH_TAKEN = 1'b1; DCACHE_STALL = 1'b1; ICACHE_STALL = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RUN); end
    cyc();
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL reset_ctl2: got %b want %b", ctl, C_RUN); end
    n_cmp++;
    if (STALL_CYCLES !== 4'd0 || BUBBLE_CYCLES !== 4'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", STALL_CYCLES, BUBBLE_CYCLES);
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    n_cmp++;
    if (ctl !== C_BUBBLE) begin n_fail++; $display("FAIL lu_bubble: got %b want %b", ctl, C_BUBBLE); end
    cyc();
    clear_inputs();
    EXMEM_RD = 5'd5; EXMEM_MemRead = 1'b1;
    IFID_RS1 = 5'd5; IFID_USE_RS1 = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_flow: got %b want %b", ctl, C_RUN); end
    n_cmp++;
    if (BUBBLE_CYCLES !== 4'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", BUBBLE_CYCLES); end
    // Same load in EX but ID does not read the register: no hazard.
    clear_inputs();
    IDEX_RD = 5'd5; IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1;
    IFID_RS1 = 5'd5; IFID_USE_RS1 = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_nouse: got %b want %b", ctl, C_RUN); end
    clear_inputs();
  endtask

  task automatic test_branch_load();
    do_reset();
    IDEX_RD = 5'd5; IDEX_RegWrite = 1'b1; IDEX_MemRead = 1'b1;
    IFID_BRANCH = 1'b1; IFID_RS1 = 5'd5; IFID_USE_RS1 = 1'b1; IFID_RS2 = 5'd0; IFID_USE_RS2 = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_BUBBLE) begin n_fail++; $display("FAIL bl_first: got %b want %b", ctl, C_BUBBLE); end
    cyc();
    IDEX_RD = 5'd0; IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0;
    EXMEM_RD = 5'd5; EXMEM_MemRead = 1'b1;
    BRANCH_TAKEN = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_BUBBLE) begin n_fail++; $display("FAIL bl_second: got %b want %b", ctl, C_BUBBLE); end
    cyc();
    EXMEM_RD = 5'd0; EXMEM_MemRead = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL bl_flows: got %b want %b", ctl, C_FLUSH); end
    n_cmp++;
    if (BUBBLE_CYCLES !== 4'd2) begin n_fail++; $display("FAIL bl_cnt: got %0d want 2", BUBBLE_CYCLES); end
    clear_inputs();
  endtask

  task automatic test_branch_alu();
    do_reset();
    IDEX_RD = 5'd7; IDEX_RegWrite = 1'b1;
    IFID_BRANCH = 1'b1; IFID_RS1 = 5'd0; IFID_USE_RS1 = 1'b1; IFID_RS2 = 5'd7; IFID_USE_RS2 = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_BUBBLE) begin n_fail++; $display("FAIL ba_bubble: got %b want %b", ctl, C_BUBBLE); end
    cyc();
    IDEX_RD = 5'd0; IDEX_RegWrite = 1'b0;
    EXMEM_RD = 5'd7;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL ba_flow: got %b want %b", ctl, C_RUN); end
    n_cmp++;
    if (BUBBLE_CYCLES !== 4'd1) begin n_fail++; $display("FAIL ba_cnt: got %0d want 1", BUBBLE_CYCLES); end
    // add x0 in EX, branch on x0 in ID: x0 never matches.
    clear_inputs();
    IDEX_RD = 5'd0; IDEX_RegWrite = 1'b1;
    IFID_BRANCH = 1'b1; IFID_RS1 = 5'd0; IFID_USE_RS1 = 1'b1; IFID_RS2 = 5'd0; IFID_USE_RS2 = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL ba_x0: got %b want %b", ctl, C_RUN); end
    clear_inputs();
  endtask

  task automatic test_dcache_stall();
    do_reset();
    set_load_use();
    DCACHE_STALL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL dc_freeze[%0d]: got %b want %b", i, ctl, C_FREEZE); end
      cyc();
    end
    clear_inputs();
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL dc_exit: got %b want %b", ctl, C_RUN); end
    n_cmp++;
    if (STALL_CYCLES !== 4'd4 || BUBBLE_CYCLES !== 4'd0) begin
      n_fail++; $display("FAIL dc_cnt: got %0d/%0d want 4/0", STALL_CYCLES, BUBBLE_CYCLES);
    end
  endtask

  task automatic test_deferred_flush();
    do_reset();
    ICACHE_STALL = 1'b1; BRANCH_TAKEN = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL df_freeze0: got %b want %b", ctl, C_FREEZE); end
    cyc();
    BRANCH_TAKEN = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL df_freeze1: got %b want %b", ctl, C_FREEZE); end
    cyc();
    ICACHE_STALL = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL df_flush: got %b want %b", ctl, C_FLUSH); end
    cyc();
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL df_once: got %b want %b", ctl, C_RUN); end
    cyc();
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL df_once2: got %b want %b", ctl, C_RUN); end
    // Taken branch during freeze but with a hazard present must not be remembered.
    ICACHE_STALL = 1'b1; BRANCH_TAKEN = 1'b1; set_load_use();
    cyc();
    clear_inputs();
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL df_hz_nopend: got %b want %b", ctl, C_RUN); end
  endtask

  task automatic test_saturate_reset();
    int exp_cnt;
    do_reset();
    DCACHE_STALL = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      exp_cnt = (i > 15) ? 15 : i;
      n_cmp++;
      if (STALL_CYCLES !== exp_cnt[W-1:0]) begin
        n_fail++; $display("FAIL sat_stall[%0d]: got %0d want %0d", i, STALL_CYCLES, exp_cnt);
      end
    end
    // Reset while the D-cache stall is still asserted.
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL rst_midfreeze: got %b want %b", ctl, C_RUN); end
    cyc();
    n_cmp++;
    if (STALL_CYCLES !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", STALL_CYCLES); end
    rst = 1'b0; DCACHE_STALL = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL rst_run: got %b want %b", ctl, C_RUN); end
    set_load_use();
    for (int i = 0; i < 17; i++) cyc();
    n_cmp++;
    if (BUBBLE_CYCLES !== 4'd15) begin n_fail++; $display("FAIL sat_bubble: got %0d want 15", BUBBLE_CYCLES); end
    n_cmp++;
    if (ctl !== C_BUBBLE) begin n_fail++; $display("FAIL sat_ctl: got %b want %b", ctl, C_BUBBLE); end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_dcache_stall();
    test_deferred_flush();
    test_saturate_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
